// File: rtl/iagc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iagc_pkg
// Brief   : Shared IAGC status codes, ADC code limits and sampler state type.
// Revision: 1.0 - initial release
// ============================================================================
package iagc_pkg;

  localparam int SAMPLER_DATA_SIZE = 14;

  localparam logic [3:0] IAGC_STATUS_RESET = 4'b0000;
  localparam logic [3:0] IAGC_STATUS_INIT  = 4'b0001;

  localparam logic [SAMPLER_DATA_SIZE-1:0] ADC_CODE_MIN = 14'h0000;
  localparam logic [SAMPLER_DATA_SIZE-1:0] ADC_CODE_MAX = 14'h3FFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sampler_state_e;

endpackage
`default_nettype wire

// File: rtl/iagc_sampler_channel.sv
`default_nettype none
// ============================================================================
// Module  : iagc_sampler_channel
// Brief   : Per-channel offset-binary conversion, over-range detect and
//           optional window averaging (enabled by IAGC_SAMPLER_AVG_EN).
// Revision: 1.0 - initial release
// ============================================================================
module iagc_sampler_channel #(
  parameter int SAMPLER_DATA_SIZE = 14,
  parameter int DECIM_LOG2_SIZE   = 3
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_clear,
  input  logic                         i_accept,
  input  logic                         i_close,
  input  logic [DECIM_LOG2_SIZE-1:0]   i_decim_log2,
  input  logic [SAMPLER_DATA_SIZE-1:0] i_raw,
  output logic [SAMPLER_DATA_SIZE-1:0] o_result,
  output logic                         o_overrange
);
  import iagc_pkg::*;

  logic [SAMPLER_DATA_SIZE-1:0] conv;

  assign conv        = {~i_raw[SAMPLER_DATA_SIZE-1], i_raw[SAMPLER_DATA_SIZE-2:0]};
  assign o_overrange = (i_raw == ADC_CODE_MIN) || (i_raw == ADC_CODE_MAX);

`ifdef IAGC_SAMPLER_AVG_EN
  // 7 guard bits hold a full 2^7-sample window without overflow.
  localparam int ACC_SIZE = SAMPLER_DATA_SIZE + 7;

  logic signed [ACC_SIZE-1:0] acc_q, acc_d, acc_sum, acc_shift;

  assign acc_sum   = acc_q + {{7{conv[SAMPLER_DATA_SIZE-1]}}, conv};
  assign acc_shift = acc_sum >>> i_decim_log2;
  assign o_result  = acc_shift[SAMPLER_DATA_SIZE-1:0];

  always_comb begin
    acc_d = acc_q;
    if (i_clear) begin
      acc_d = '0;
    end else if (i_accept) begin
      acc_d = i_close ? '0 : acc_sum;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_avg;

  assign o_result   = conv;
  assign unused_avg = ^{i_clock, i_reset_n, i_clear, i_accept, i_close, i_decim_log2};
`endif

endmodule
`default_nettype wire

// File: rtl/iagc_sampler.sv
`default_nettype none
// ============================================================================
// Module  : iagc_sampler
// Brief   : Decimates reference/error ADC pairs over 2^k valid pulses and
//           strobes two's-complement samples. Averaging: IAGC_SAMPLER_AVG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module iagc_sampler #(
  parameter int SAMPLER_DATA_SIZE = 14,
  parameter int IAGC_STATUS_SIZE  = 4,
  parameter int DECIM_LOG2_SIZE   = 3
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0]  i_iagc_status,
  input  logic                         i_adc_valid,
  input  logic [SAMPLER_DATA_SIZE-1:0] i_adc_reference,
  input  logic [SAMPLER_DATA_SIZE-1:0] i_adc_error,
  input  logic [DECIM_LOG2_SIZE-1:0]   i_decim_log2,
  output logic                         o_sample,
  output logic [SAMPLER_DATA_SIZE-1:0] o_reference,
  output logic [SAMPLER_DATA_SIZE-1:0] o_error,
  output logic                         o_overrange
);
  import iagc_pkg::*;

  localparam int CNT_SIZE = (2 ** DECIM_LOG2_SIZE) - 1;

  sampler_state_e               state_q, state_d;
  logic [DECIM_LOG2_SIZE-1:0]   k_q, k_d;
  logic [CNT_SIZE-1:0]          cnt_q, cnt_d, win_mask;
  logic                         ovr_q, ovr_d;
  logic                         sample_q, sample_d;
  logic [SAMPLER_DATA_SIZE-1:0] reference_q, reference_d, error_q, error_d;
  logic                         overrange_q, overrange_d;
  logic                         ch_clear, ch_accept, ch_close;
  logic [SAMPLER_DATA_SIZE-1:0] ref_result, err_result;
  logic                         ref_hit, err_hit;
  logic                         status_reset;

  assign status_reset = (i_iagc_status == IAGC_STATUS_RESET);

  // Terminal count is 2^k-1: the low k bits set.
  always_comb begin
    for (int i = 0; i < CNT_SIZE; i++) begin
      win_mask[i] = (int'(k_q) > i);
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
    sample_d    = 1'b0;
    reference_d = reference_q;
    error_d     = error_q;
    overrange_d = overrange_q;
    ch_clear    = 1'b0;
    ch_accept   = 1'b0;
    ch_close    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        ovr_d    = 1'b0;
        ch_clear = 1'b1;
        if (!status_reset) begin
          state_d = RUN;
          k_d     = i_decim_log2;
        end
      end
      RUN: begin
        if (status_reset) begin
          state_d  = IDLE;
          cnt_d    = '0;
          ovr_d    = 1'b0;
          ch_clear = 1'b1;
        end else if (i_adc_valid) begin
          ch_accept = 1'b1;
          if (cnt_q == win_mask) begin
            ch_close    = 1'b1;
            cnt_d       = '0;
            ovr_d       = 1'b0;
            sample_d    = 1'b1;
            reference_d = ref_result;
            error_d     = err_result;
            overrange_d = ovr_q | ref_hit | err_hit;
          end else begin
            cnt_d = cnt_q + 1'b1;
            ovr_d = ovr_q | ref_hit | err_hit;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      sample_q    <= 1'b0;
      reference_q <= '0;
      error_q     <= '0;
      overrange_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      sample_q    <= sample_d;
      reference_q <= reference_d;
      error_q     <= error_d;
      overrange_q <= overrange_d;
    end
  end

  iagc_sampler_channel #(
    .SAMPLER_DATA_SIZE (SAMPLER_DATA_SIZE),
    .DECIM_LOG2_SIZE   (DECIM_LOG2_SIZE)
  ) u_ch_reference (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_clear      (ch_clear),
    .i_accept     (ch_accept),
    .i_close      (ch_close),
    .i_decim_log2 (k_q),
    .i_raw        (i_adc_reference),
    .o_result     (ref_result),
    .o_overrange  (ref_hit)
  );

  iagc_sampler_channel #(
    .SAMPLER_DATA_SIZE (SAMPLER_DATA_SIZE),
    .DECIM_LOG2_SIZE   (DECIM_LOG2_SIZE)
  ) u_ch_error (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_clear      (ch_clear),
    .i_accept     (ch_accept),
    .i_close      (ch_close),
    .i_decim_log2 (k_q),
    .i_raw        (i_adc_error),
    .o_result     (err_result),
    .o_overrange  (err_hit)
  );

  assign o_sample    = sample_q;
  assign o_reference = reference_q;
  assign o_error     = error_q;
  assign o_overrange = overrange_q;

endmodule
`default_nettype wire

// File: tb/tb_iagc_sampler.sv
`default_nettype none
// ============================================================================
// Module  : tb_iagc_sampler
// Brief   : Self-checking bench for iagc_sampler against a window-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iagc_sampler;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [3:0]  i_iagc_status = 4'b0000;
  logic        i_adc_valid = 1'b0;
  logic [13:0] i_adc_reference = 14'h2000;
  logic [13:0] i_adc_error = 14'h2000;
  logic [2:0]  i_decim_log2 = 3'd0;
  logic        o_sample;
  logic [13:0] o_reference;
  logic [13:0] o_error;
  logic        o_overrange;

  iagc_sampler #(
    .SAMPLER_DATA_SIZE (14),
    .IAGC_STATUS_SIZE  (4),
    .DECIM_LOG2_SIZE   (3)
  ) dut (
    .i_clock         (i_clock),
    .i_reset_n       (i_reset_n),
    .i_iagc_status   (i_iagc_status),
    .i_adc_valid     (i_adc_valid),
    .i_adc_reference (i_adc_reference),
    .i_adc_error     (i_adc_error),
    .i_decim_log2    (i_decim_log2),
    .o_sample        (o_sample),
    .o_reference     (o_reference),
    .o_error         (o_error),
    .o_overrange     (o_overrange)
  );

  always #5 i_clock = ~i_clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Window-level reference model: collect signed samples, resolve on the 2^k-th.
  bit   m_run;
  int   m_k;
  int   m_ref[$];
  int   m_err[$];
  bit   m_or;
  bit   exp_sample;
  int   exp_ref, exp_err;
  bit   exp_ov;

  function automatic int to_signed(input logic [13:0] raw);
    return int'(raw) - 8192;
  endfunction

  function automatic bit is_extreme(input logic [13:0] raw);
    return (raw == 14'h0000) || (raw == 14'h3FFF);
  endfunction

  function automatic int window_value(input int q[$], input int k);
    int sum;
`ifdef IAGC_SAMPLER_AVG_EN
    sum = 0;
    foreach (q[i]) sum += q[i];
    return (sum >>> k) & 16'h3FFF;
`else
    sum = q[q.size()-1];
    return sum & 16'h3FFF;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_k = 0; m_or = 0;
    m_ref.delete(); m_err.delete();
    exp_sample = 0; exp_ref = 0; exp_err = 0; exp_ov = 0;
  endtask

  task automatic model_step();
    exp_sample = 0;
    if (!i_reset_n) begin
      model_reset();
    end else if (!m_run) begin
      m_ref.delete(); m_err.delete(); m_or = 0;
      if (i_iagc_status != 4'b0000) begin
        m_run = 1;
        m_k   = int'(i_decim_log2);
      end
    end else if (i_iagc_status == 4'b0000) begin
      m_run = 0;
      m_ref.delete(); m_err.delete(); m_or = 0;
    end else if (i_adc_valid) begin
      m_ref.push_back(to_signed(i_adc_reference));
      m_err.push_back(to_signed(i_adc_error));
      m_or = m_or | is_extreme(i_adc_reference) | is_extreme(i_adc_error);
      if (m_ref.size() == (1 << m_k)) begin
        exp_sample = 1;
        exp_ref    = window_value(m_ref, m_k);
        exp_err    = window_value(m_err, m_k);
        exp_ov     = m_or;
        m_ref.delete(); m_err.delete(); m_or = 0;
      end
    end
  endtask

  task automatic compare_outputs(input string phase);
    check_eq({phase, ".sample"},    32'(o_sample),    32'(exp_sample));
    check_eq({phase, ".reference"}, 32'(o_reference), 32'(exp_ref));
    check_eq({phase, ".error"},     32'(o_error),     32'(exp_err));
    check_eq({phase, ".overrange"}, 32'(o_overrange), 32'(exp_ov));
  endtask

  task automatic cycle(input string phase);
    @(posedge i_clock);
    model_step();
    #1;
    compare_outputs(phase);
  endtask

  task automatic drive(input string phase, input logic [3:0] st, input logic v,
                       input logic [13:0] r, input logic [13:0] e, input logic [2:0] k);
    i_iagc_status   = st;
    i_adc_valid     = v;
    i_adc_reference = r;
    i_adc_error     = e;
    i_decim_log2    = k;
    cycle(phase);
  endtask

  task automatic async_reset(input string phase);
    #2;
    i_reset_n = 1'b0;
    #1;
    model_reset();
    compare_outputs({phase, ".async"});
    i_adc_valid = 1'b0;
    cycle(phase);
    cycle(phase);
    i_reset_n = 1'b1;
  endtask

  function automatic logic [13:0] rnd_raw();
    case ($urandom_range(0, 7))
      0:       return 14'h0000;
      1:       return 14'h3FFF;
      default: return 14'($urandom);
    endcase
  endfunction

  initial begin
    model_reset();
    #1;
    compare_outputs("reset");
    cycle("reset");
    cycle("reset");
    i_reset_n = 1'b1;
    drive("reset", 4'h0, 1'b0, 14'h2000, 14'h2000, 3'd0);

    // k=0 conversion boundaries
    drive("t2", 4'h1, 1'b0, 14'h2000, 14'h1FFF, 3'd0);
    drive("t2", 4'h1, 1'b1, 14'h2000, 14'h1FFF, 3'd0);
    drive("t2", 4'h1, 1'b1, 14'h3FFF, 14'h1FFF, 3'd0);
    drive("t2", 4'h1, 1'b1, 14'h0000, 14'h1FFF, 3'd0);
    drive("t2", 4'h1, 1'b0, 14'h0000, 14'h1FFF, 3'd0);
    check_eq("t2.last_ref", 32'(o_reference), 32'h2000);
    check_eq("t2.last_err", 32'(o_error), 32'h3FFF);

    // k=2 decimate: closing pair 0x2005
    drive("t3", 4'h0, 1'b0, 14'h2000, 14'h2000, 3'd2);
    drive("t3", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd2);
    for (int i = 0; i < 3; i++) drive("t3", 4'h1, 1'b1, 14'h2005, 14'h2005, 3'd2);
    drive("t3", 4'h1, 1'b1, 14'h2005, 14'h2007, 3'd2);
    check_eq("t3.strobe", 32'(o_sample), 32'd1);
`ifndef IAGC_SAMPLER_AVG_EN
    check_eq("t3.ref", 32'(o_reference), 32'd5);
`endif
    drive("t3", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd2);

    // status abort with k=3
    drive("t4", 4'h0, 1'b0, 14'h2000, 14'h2000, 3'd3);
    drive("t4", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd3);
    for (int i = 0; i < 5; i++) drive("t4", 4'h1, 1'b1, rnd_raw(), rnd_raw(), 3'd3);
    drive("t4", 4'h0, 1'b0, 14'h2000, 14'h2000, 3'd3);
    drive("t4", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd3);
    for (int i = 0; i < 8; i++) drive("t4", 4'h1, 1'b1, rnd_raw(), rnd_raw(), 3'd3);
    drive("t4", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd3);

    // k change mid-run ignored until restart
    drive("t5", 4'h0, 1'b0, 14'h2000, 14'h2000, 3'd2);
    drive("t5", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd2);
    for (int i = 0; i < 8; i++) drive("t5", 4'h1, 1'b1, rnd_raw(), rnd_raw(), 3'd0);
    drive("t5", 4'h0, 1'b0, 14'h2000, 14'h2000, 3'd0);
    drive("t5", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd0);
    for (int i = 0; i < 4; i++) drive("t5", 4'h1, 1'b1, rnd_raw(), rnd_raw(), 3'd5);

    // async reset with a pending window
    drive("t1", 4'h0, 1'b0, 14'h2000, 14'h2000, 3'd2);
    drive("t1", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd2);
    for (int i = 0; i < 3; i++) drive("t1", 4'h1, 1'b1, rnd_raw(), rnd_raw(), 3'd2);
    async_reset("t1");
    drive("t1", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd2);
    for (int i = 0; i < 5; i++) drive("t1", 4'h1, 1'b1, rnd_raw(), rnd_raw(), 3'd2);

`ifdef IAGC_SAMPLER_AVG_EN
    // averaging with floor on negatives
    drive("t6", 4'h0, 1'b0, 14'h2000, 14'h2000, 3'd2);
    drive("t6", 4'h1, 1'b0, 14'h2000, 14'h2000, 3'd2);
    drive("t6", 4'h1, 1'b1, 14'h2001, 14'h1FFF, 3'd2);
    drive("t6", 4'h1, 1'b1, 14'h2003, 14'h1FFF, 3'd2);
    drive("t6", 4'h1, 1'b1, 14'h1FFF, 14'h1FFF, 3'd2);
    drive("t6", 4'h1, 1'b1, 14'h2005, 14'h1FFF, 3'd2);
    check_eq("t6.avg_ref", 32'(o_reference), 32'd2);
    check_eq("t6.avg_err", 32'(o_error), 32'h3FFF);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] st;
      st = ($urandom_range(0, 99) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 599) == 0) begin
        async_reset("rand");
      end
      drive("rand", st, 1'($urandom_range(0, 1)), rnd_raw(), rnd_raw(), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
